// File: rtl/warp_pkg.sv
// Shared definitions for the warp scan controller: default geometry, FSM
// state encoding and the RGB565 pixel type.
package warp_pkg;

  localparam int unsigned H_ACT_DEFAULT      = 640;
  localparam int unsigned V_ACT_DEFAULT      = 480;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
  localparam int unsigned PIPE_LAT_DEFAULT   = 3;

  localparam int unsigned PIX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pix_t;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/warp_pix_fifo.sv
// Show-ahead pixel FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; otherwise it drops.
module warp_pix_fifo
  import warp_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [PIX_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [PIX_W-1:0] rd_data_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [CW-1:0]    count_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok   = push_i && (!full || pop_ok);
  assign drop_o    = push_i && !push_ok;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read side is qualified by empty_o.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/warp_scan_ctrl.sv
// Raster scan controller: issues destination coordinates to the warp datapath
// under FIFO credit, buffers returned pixels and streams them to the sink.
module warp_scan_ctrl
  import warp_pkg::*;
#(
  parameter int unsigned H_ACT      = H_ACT_DEFAULT,
  parameter int unsigned V_ACT      = V_ACT_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned PIPE_LAT   = PIPE_LAT_DEFAULT
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iFRAME_START,
  output logic       oBUSY,
  output logic       oFRAME_DONE,
  output logic       oSTART,
  output logic [9:0] oX,
  output logic [9:0] oY,
  input  logic       iH_READY,
  input  logic [4:0] iR,
  input  logic [5:0] iG,
  input  logic [4:0] iB,
  output logic       oPIX_VALID,
  input  logic       iPIX_READY,
  output logic [4:0] oPIX_R,
  output logic [5:0] oPIX_G,
  output logic [4:0] oPIX_B,
  output logic       oPIX_EOL,
  output logic       oPIX_LAST,
  output logic       oOVF,
  output logic [1:0] oSTATE
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0]  X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACT - 1);

  if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 4) || (PIPE_LAT < 1)) begin : g_bad_param
    $error("warp_scan_ctrl: FIFO_DEPTH must be a power of 2 >= 4 and PIPE_LAT >= 1");
  end

  scan_state_e   state_q;
  logic [9:0]    x_q, y_q;
  logic [9:0]    x_out_q, y_out_q;
  logic          start_q, busy_q, done_q;
  logic [OW-1:0] outst_q, outst_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    ox_q, oy_q;

  logic [OW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_drop;
  pix_t          push_pix, rd_pix;
  logic          pop;
  logic [OW:0]   in_use;
  logic          issue;
  logic          ret_ok;
  logic          stray_ret;

  // Sink handshake: a pixel transfers on a rising edge where oPIX_VALID and
  // iPIX_READY are both high; while VALID is high without READY the pixel
  // fields hold. VALID never depends on READY.
  assign push_pix   = '{r: iR, g: iG, b: iB};
  assign oPIX_VALID = !fifo_empty;
  assign pop        = oPIX_VALID && iPIX_READY;

  warp_pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .push_i      (iH_READY),
    .push_data_i (push_pix),
    .pop_i       (pop),
    .rd_data_o   (rd_pix),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop),
    .count_o     (fifo_count)
  );

  // Every issued coordinate owns a FIFO slot until its pixel leaves, so the
  // datapath can never return more than the FIFO can hold.
  assign in_use    = {1'b0, fifo_count} + {1'b0, outst_q};
  assign issue     = (state_q == ST_SCAN) && (in_use < (OW + 1)'(FIFO_DEPTH));
  assign ret_ok    = iH_READY && (outst_q != '0);
  assign stray_ret = iH_READY && (outst_q == '0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iFRAME_START) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ST_SCAN: begin
          if (issue) begin
            start_q <= 1'b1;
            x_out_q <= x_q;
            y_out_q <= y_q;
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q     <= '0;
                state_q <= ST_DRAIN;
              end else begin
                y_q <= y_q + 10'd1;
              end
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        ST_DRAIN: begin
          if ((outst_q == '0) && fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A return with nothing outstanding is spurious: it is flagged and does not
  // cancel a coordinate being issued in the same cycle.
  always_comb begin
    outst_d = outst_q;
    case ({issue, ret_ok})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    ovf_d = ovf_q || stray_ret || fifo_drop;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      outst_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (pop) begin
      if (ox_q == X_LAST) begin
        ox_q <= '0;
        oy_q <= (oy_q == Y_LAST) ? 10'd0 : oy_q + 10'd1;
      end else begin
        ox_q <= ox_q + 10'd1;
      end
    end
  end

  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;
  assign oSTART      = start_q;
  assign oX          = x_out_q;
  assign oY          = y_out_q;
  assign oOVF        = ovf_q;
  assign oSTATE      = state_q;
  assign oPIX_R      = oPIX_VALID ? rd_pix.r : 5'd0;
  assign oPIX_G      = oPIX_VALID ? rd_pix.g : 6'd0;
  assign oPIX_B      = oPIX_VALID ? rd_pix.b : 5'd0;
  assign oPIX_EOL    = oPIX_VALID && (ox_q == X_LAST);
  assign oPIX_LAST   = oPIX_EOL && (oy_q == Y_LAST);

endmodule

// File: doc/warp_scan_ctrl.md
WARP_SCAN_CTRL -- requirements
Module: warp_scan_ctrl

Interface
REQ-001 Parameter H_ACT, 640: active pixels per line.
REQ-002 Parameter V_ACT, 480: active lines per frame.
REQ-003 Parameter FIFO_DEPTH, 8: output pixel FIFO entries (power of 2, >=4).
REQ-004 Parameter PIPE_LAT, 3: fixed warp-datapath latency, start to ready, in cycles.
REQ-005 iCLK  in  1  sole clock; all state changes on the rising edge.
REQ-006 iRST  in  1  reset; asynchronous, active-high.
REQ-007 iFRAME_START  in  1  one-cycle pulse; begins a frame scan.
REQ-008 oBUSY  out  1  high in any state other than IDLE.
REQ-009 oFRAME_DONE  out  1  one-cycle pulse at frame completion.
REQ-010 oSTART  out  1  issue strobe to the warp datapath.
REQ-011 oX, oY  out  10 each  destination coordinate issued with oSTART.
REQ-012 iH_READY  in  1  warp datapath return strobe.
REQ-013 iR, iG, iB  in  5/6/5  returned RGB565 pixel, valid with iH_READY.
REQ-014 oPIX_VALID  out  1 / iPIX_READY  in  1  sink handshake.
REQ-015 oPIX_R, oPIX_G, oPIX_B  out  5/6/5  pixel to sink.
REQ-016 oPIX_EOL, oPIX_LAST  out  1 each  last pixel of line / last pixel of frame, qualified by oPIX_VALID.
REQ-017 oOVF  out  1  sticky overflow flag.

Function
REQ-018 States SHALL be IDLE, SCAN, DRAIN, DONE.
REQ-019 IDLE: iFRAME_START -> SCAN, issue counters x=y=0; iFRAME_START in any other state SHALL be ignored.
REQ-020 SCAN: oSTART=1 (registered, oX/oY=x/y) only when fifo_count+outstanding < FIFO_DEPTH (credit).
REQ-021 Each issue advances x; at x=H_ACT-1, x wraps to 0 and y increments.
REQ-022 Issue of (H_ACT-1, V_ACT-1) SHALL move SCAN -> DRAIN; no further oSTART until next frame.
REQ-023 DRAIN -> DONE when outstanding=0 and FIFO empty; DONE asserts oFRAME_DONE for one cycle -> IDLE.
REQ-024 outstanding: +1 on issue, -1 on iH_READY, unchanged when both occur in the same cycle; width ceil(log2(FIFO_DEPTH+1)).
REQ-025 iH_READY SHALL push {iR,iG,iB} into the FIFO; FIFO is show-ahead, oPIX_VALID = not empty.
REQ-026 Pop on oPIX_VALID && iPIX_READY; push and pop in the same cycle SHALL both occur, count unchanged, including at full.
REQ-027 Push when full without pop SHALL drop the pixel and set oOVF, held until reset.
REQ-028 iH_READY when outstanding=0 SHALL set oOVF and still push if space.
REQ-029 Output counters ox/oy advance on each pop with the same wrap rule; oPIX_EOL = (ox=H_ACT-1), oPIX_LAST = oPIX_EOL && (oy=V_ACT-1).
REQ-030 oPIX_R/G/B SHALL hold stable while oPIX_VALID && !iPIX_READY.
REQ-031 With iPIX_READY held high, steady-state issue rate SHALL be one pixel per cycle; first pixel reaches oPIX_VALID PIPE_LAT+1 cycles after first oSTART.

Reset
REQ-032 iRST SHALL force IDLE; oSTART, oX, oY, oBUSY, oFRAME_DONE, oPIX_*, oOVF = 0; counters, outstanding, FIFO pointers = 0.
REQ-033 Reset mid-frame SHALL abort the scan and flush the FIFO; returns arriving after reset release with outstanding=0 set oOVF (REQ-028).

Structure
REQ-034 Package warp_pkg SHALL hold H_ACT, V_ACT, FIFO_DEPTH, PIPE_LAT defaults, the state enum, and the RGB565 pixel type.
REQ-035 FIFO SHALL be a sub-module warp_pix_fifo (show-ahead, count output); controller, credit and output counters stay in warp_scan_ctrl.

Verification (bench uses H_ACT=4, V_ACT=2, FIFO_DEPTH=8, PIPE_LAT=3 model)
REQ-036 Reset then iFRAME_START, sink always ready -> 8 oSTART on consecutive cycles, (0,0)..(3,1); 8 pixels in order; oPIX_EOL on 4th and 8th; oPIX_LAST on 8th; one oFRAME_DONE; oOVF=0.
REQ-037 iPIX_READY=0 whole frame -> exactly 8 oSTART then stall; FIFO full with outstanding=0; release ready -> 8 pixels, oFRAME_DONE, no drop.
REQ-038 iPIX_READY toggling 1/0 each cycle -> pixel data matches issue order; outputs stable while stalled; oOVF=0.
REQ-039 iFRAME_START pulsed again mid-SCAN -> ignored; exactly 8 pixels, one oFRAME_DONE.
REQ-040 iRST asserted after 3 issues -> all outputs 0 immediately; after release, stray iH_READY -> oOVF=1; new frame still completes with 8 pixels.
REQ-041 Forced iH_READY with FIFO full, iPIX_READY=0 -> pixel dropped, count stays 8, oOVF=1 sticky.
